// File: rtl/fix_cmul_round_sat.sv
// ---------------------------------------------------------------------------
// fix_cmul_round_sat
//
// Post-multiplier stage of the FFT twiddle path. Four raw 64-bit products
// from Fix32_16mult instances (ar*br, ai*bi, ar*bi, ai*br) are combined into
// a complex product, rounded back to Q(32-FRAC).FRAC and buffered in a small
// show-ahead FIFO with a valid/ready output. The multipliers cannot be
// stalled, so operands are only accepted while the FIFO plus everything
// already in flight still fits. An accepted operand can then never find the
// FIFO full.
//
// Optional feature macro: FIX_CMUL_SAT_EN
//   defined   : results outside the 32-bit range clamp to 0x8000_0000 /
//               0x7FFF_FFFF and the entry's ovf flag is set.
//   undefined : results wrap (low 32 bits kept). ovf is tied 0.
//
// Ports
//   clk, rst            clock (rising edge), synchronous active-high reset
//   in_valid, in_ready  operands presented to the multipliers / credit
//   p_rr, p_ii          ar*br, ai*bi   (signed, 2*FRAC fractional bits)
//   p_ri, p_ir          ar*bi, ai*br
//   out_valid/out_ready FIFO head handshake
//   out_re, out_im      head result, signed Q(32-FRAC).FRAC
//   ovf                 head entry saturated (re or im)
//
// Timing: acceptance edge T -> FIFO write at edge T+MULT_LAT+2.
// ---------------------------------------------------------------------------

// Rounding/narrowing for one component (re or im) of the complex product.
// The input is the 65-bit S1 sum. Rounding is half-up (toward +inf) at bit
// FRAC-1, followed by an arithmetic shift right by FRAC.
module fix_cmul_rnd_lane #(
    parameter int FRAC = 16
) (
    input  logic [64:0] w,
    output logic [31:0] q,
    output logic        ovf
);
    // One extra bit of headroom: the 65-bit sum can reach 2^64-1, and
    // adding the rounding constant must not wrap.
    localparam logic [65:0] RND = 66'(1) << (FRAC - 1);

    logic        [65:0] biased;
    logic signed [65:0] shifted;

    assign biased  = {w[64], w} + RND;
    assign shifted = $signed(biased) >>> FRAC;

`ifdef FIX_CMUL_SAT_EN
    logic fits;

    // The value fits in 32 signed bits iff bits [65:31] are all sign copies.
    assign fits = (shifted[65:31] == '0) || (shifted[65:31] == '1);

    always_comb begin
        q   = shifted[31:0];
        ovf = 1'b0;
        if (!fits) begin
            ovf = 1'b1;
            q   = shifted[65] ? 32'h8000_0000 : 32'h7FFF_FFFF;
        end
    end
`else
    logic unused_hi;

    assign q         = shifted[31:0];
    assign ovf       = 1'b0;
    assign unused_hi = ^shifted[65:32];
`endif
endmodule

module fix_cmul_round_sat #(
    parameter int MULT_LAT = 3,
    parameter int FRAC     = 16,
    parameter int DEPTH    = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [63:0] p_rr,
    input  logic [63:0] p_ii,
    input  logic [63:0] p_ri,
    input  logic [63:0] p_ir,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_re,
    output logic [31:0] out_im,
    output logic        ovf
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
`ifdef FIX_CMUL_SAT_EN
    localparam int EW = 65;   // {ovf, re, im}
`else
    localparam int EW = 64;   // {re, im}
`endif

    // ---------------------------------------------------------------
    // Accept and valid delay line matching the multiplier latency
    // ---------------------------------------------------------------
    logic                acc;
    logic [MULT_LAT-1:0] vld_pipe;
    logic                pv;

    assign acc = in_valid & in_ready;
    // The p_* inputs carry the accepted operands' products in this cycle.
    assign pv  = vld_pipe[MULT_LAT-1];

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_pipe <= '0;
        end else begin
            vld_pipe[0] <= acc;
            for (int i = 1; i < MULT_LAT; i++) vld_pipe[i] <= vld_pipe[i-1];
        end
    end

    // ---------------------------------------------------------------
    // S1: complex combine (lane 0 = re, lane 1 = im), 65-bit exact
    // S2: rounded and narrowed results
    // ---------------------------------------------------------------
    logic             s1_v, s2_v;
    logic [1:0][64:0] s1_w;
    logic [1:0][31:0] rnd_q;
    logic [1:0]       rnd_ovf;
    logic [1:0][31:0] s2_q;
`ifdef FIX_CMUL_SAT_EN
    logic             s2_ovf;
`else
    logic             unused_ovf;
    assign unused_ovf = |rnd_ovf;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_v <= 1'b0;
            s2_v <= 1'b0;
            s1_w <= '0;
            s2_q <= '0;
`ifdef FIX_CMUL_SAT_EN
            s2_ovf <= 1'b0;
`endif
        end else begin
            s1_v <= pv;
            s2_v <= s1_v;
            // Products are only meaningful on pv. Anything else the
            // multipliers emit (idle or post-reset) is ignored here.
            if (pv) begin
                s1_w[0] <= {p_rr[63], p_rr} - {p_ii[63], p_ii};
                s1_w[1] <= {p_ri[63], p_ri} + {p_ir[63], p_ir};
            end
            if (s1_v) begin
                s2_q <= rnd_q;
`ifdef FIX_CMUL_SAT_EN
                s2_ovf <= |rnd_ovf;
`endif
            end
        end
    end

    for (genvar g = 0; g < 2; g++) begin : g_lane
        fix_cmul_rnd_lane #(.FRAC(FRAC)) u_lane (
            .w   (s1_w[g]),
            .q   (rnd_q[g]),
            .ovf (rnd_ovf[g])
        );
    end

    // ---------------------------------------------------------------
    // Output FIFO (show-ahead)
    // ---------------------------------------------------------------
    logic [EW-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count;
    logic [EW-1:0] entry, head;
    logic          push, pop;

`ifdef FIX_CMUL_SAT_EN
    assign entry = {s2_ovf, s2_q[0], s2_q[1]};
`else
    assign entry = {s2_q[0], s2_q[1]};
`endif

    assign push      = s2_v;
    assign out_valid = (count != '0);
    assign pop       = out_valid & out_ready;   // pop on empty is impossible
    assign head      = mem[rd_ptr];

    // Storage is not reset. The outputs below are gated by out_valid,
    // so stale contents are never visible.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= entry;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;   // wraps modulo DEPTH
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + CW'(push) - CW'(pop);
        end
    end

    assign out_re = out_valid ? head[63:32] : '0;
    assign out_im = out_valid ? head[31:0]  : '0;
`ifdef FIX_CMUL_SAT_EN
    assign ovf    = out_valid & head[64];
`else
    assign ovf    = 1'b0;
`endif

    // ---------------------------------------------------------------
    // Credit: buffered plus in-flight results must stay below DEPTH.
    // Both terms are registered, so a pop this cycle only frees credit
    // next cycle. This keeps in_ready independent of out_ready.
    // ---------------------------------------------------------------
    int inflight;

    always_comb begin
        inflight = 0;
        for (int i = 0; i < MULT_LAT; i++) inflight = inflight + int'(vld_pipe[i]);
        inflight = inflight + int'(s1_v) + int'(s2_v);
    end

    assign in_ready = (int'(count) + inflight) < DEPTH;

    // The credit scheme guarantees that nothing is pushed into a full FIFO
    // unless the head leaves in the same cycle.
    a_no_overflow: assert property (@(posedge clk) disable iff (rst)
        !(push && !pop && (count == CW'(DEPTH))));

endmodule

// File: tb/tb_fix_cmul_round_sat.sv
`timescale 1ns/1ps
module tb_fix_cmul_round_sat;
    localparam int MULT_LAT = 3;
    localparam int DEPTH    = 4;

    typedef struct packed {
        logic [63:0] rr, ii, ri, ir;
    } prod_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [63:0] p_rr = '0, p_ii = '0, p_ri = '0, p_ir = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_re, out_im;
    logic        ovf;

    int checks = 0, failures = 0;
    int cyc = 0, acc_cnt = 0, pop_cnt = 0, outst = 0;
    prod_t cur_ops = '0;
    prod_t h0 = '0, h1 = '0, h2 = '0;
    logic [64:0] sb [$];   // expected {ovf, re, im}, in order

    fix_cmul_round_sat #(.MULT_LAT(MULT_LAT), .FRAC(16), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .p_rr(p_rr), .p_ii(p_ii), .p_ri(p_ri), .p_ir(p_ir),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_re(out_re), .out_im(out_im), .ovf(ovf)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Un-stallable multiplier model: operands presented in the cycle that
    // ends at edge E appear on p_* in the cycle after edge E+2.
    initial forever begin
        @(posedge clk);
        h2 = h1; h1 = h0; h0 = cur_ops;
        #1;
        p_rr = h2.rr; p_ii = h2.ii; p_ri = h2.ri; p_ir = h2.ir;
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Reference: exact integer arithmetic, round half up, then range check.
    function automatic void narrow(input logic signed [127:0] v,
                                   output logic [31:0] q, output logic o);
        logic signed [127:0] s;
        s = (v + 128'sd32768) >>> 16;
        q = s[31:0];
        o = 1'b0;
`ifdef FIX_CMUL_SAT_EN
        if (s > 128'sd2147483647) begin q = 32'h7FFF_FFFF; o = 1'b1; end
        else if (s < -128'sd2147483648) begin q = 32'h8000_0000; o = 1'b1; end
`endif
    endfunction

    function automatic logic [64:0] ref_out(input prod_t p);
        logic signed [127:0] a, b, c, d;
        logic [31:0] re, im;
        logic o1, o2;
        a = $signed(p.rr); b = $signed(p.ii);
        c = $signed(p.ri); d = $signed(p.ir);
        narrow(a - b, re, o1);
        narrow(c + d, im, o2);
        return {o1 | o2, re, im};
    endfunction

    function automatic logic [63:0] rand_p();
        logic [31:0] lo;
        lo = $urandom;
        case ($urandom_range(0, 2))
            0:       return {$urandom, $urandom};
            1:       return {{32{lo[31]}}, lo};
            default: return {{40{lo[23]}}, lo[23:0]};
        endcase
    endfunction

    function automatic prod_t rand_ops();
        prod_t p;
        p.rr = rand_p(); p.ii = rand_p(); p.ri = rand_p(); p.ir = rand_p();
        return p;
    endfunction

    // Scoreboard monitor: decides acceptances and pops at the negedge,
    // before the edge that commits them.
    initial forever begin
        logic [64:0] e;
        @(negedge clk);
        if (rst) begin
            sb.delete();
            outst = 0;
        end else begin
            chk("in_ready_credit", 64'(in_ready), 64'(outst < DEPTH));
            if (in_valid && in_ready) begin
                sb.push_back(ref_out(cur_ops));
                outst++;
                acc_cnt++;
            end
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL unexpected_result: got re=%h im=%h expected no result", out_re, out_im);
                end else begin
                    e = sb.pop_front();
                    chk("sb_re",  64'(out_re), 64'(e[63:32]));
                    chk("sb_im",  64'(out_im), 64'(e[31:0]));
                    chk("sb_ovf", 64'(ovf),    64'(e[64]));
                end
                outst--;
                pop_cnt++;
            end
        end
    end

    task automatic step();
        @(posedge clk); #1;
    endtask

    // One operand into an idle pipe. Checks latency and the given result.
    task automatic single(input string nm, input prod_t p,
                          input logic [31:0] ere, input logic [31:0] eim, input logic eovf);
        int t0;
        bit seen;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        cur_ops   = p;
        @(negedge clk);
        chk({nm, "_accept"}, 64'(in_ready), 64'd1);
        t0 = cyc + 1;
        step();
        in_valid = 1'b0;
        cur_ops  = rand_ops();
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
        end
        if (!seen) begin
            checks++; failures++;
            $display("FAIL %s_timeout: got no out_valid expected one within 20 cycles", nm);
        end else begin
            chk({nm, "_lat"}, 64'(cyc - t0), 64'd5);
            chk({nm, "_re"},  64'(out_re), 64'(ere));
            chk({nm, "_im"},  64'(out_im), 64'(eim));
            chk({nm, "_ovf"}, 64'(ovf),    64'(eovf));
        end
        step();
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int a0, p0, n;
        cur_ops = rand_ops();
        rst = 1'b1;
        repeat (3) step();
        rst = 1'b0;
        @(negedge clk);
        chk("rst_in_ready",  64'(in_ready),  64'd1);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_re",    64'(out_re),    64'd0);
        chk("rst_out_im",    64'(out_im),    64'd0);
        chk("rst_ovf",       64'(ovf),       64'd0);
        step();

        // Basic complex product: (1.5+0.5j)*(2-1j) = 3.5-0.5j
        single("cmul", '{rr: 64'h3_0000_0000, ii: 64'hFFFF_FFFF_8000_0000,
                         ri: 64'hFFFF_FFFE_8000_0000, ir: 64'h1_0000_0000},
               32'h0003_8000, 32'hFFFF_8000, 1'b0);

        // Rounding half up
        single("rnd_half", '{rr: 64'h8000, ii: 64'h0, ri: 64'h0, ir: 64'h0},
               32'h1, 32'h0, 1'b0);
        single("rnd_neg_half", '{rr: 64'hFFFF_FFFF_FFFF_8000, ii: 64'h0, ri: 64'h0, ir: 64'h0},
               32'h0, 32'h0, 1'b0);
        single("rnd_below", '{rr: 64'h1_7FFF, ii: 64'h0, ri: 64'h0, ir: 64'h0},
               32'h1, 32'h0, 1'b0);

        // Out-of-range result
`ifdef FIX_CMUL_SAT_EN
        single("sat_pos", '{rr: 64'h3FFF_FFFF_0000_0001, ii: 64'h0, ri: 64'h0, ir: 64'h0},
               32'h7FFF_FFFF, 32'h0, 1'b1);
`else
        single("wrap_pos", '{rr: 64'h3FFF_FFFF_0000_0001, ii: 64'h0, ri: 64'h0, ir: 64'h0},
               32'hFFFF_0000, 32'h0, 1'b0);
`endif

        // Backpressure: credit stops at DEPTH, then drain in order
        out_ready = 1'b0;
        in_valid  = 1'b1;
        a0 = acc_cnt;
        repeat (12) begin cur_ops = rand_ops(); step(); end
        @(negedge clk);
        chk("bp_accepts",  64'(acc_cnt - a0), 64'd4);
        chk("bp_in_ready", 64'(in_ready),     64'd0);
        step();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        p0 = pop_cnt;
        repeat (12) step();
        @(negedge clk);
        chk("bp_pops",        64'(pop_cnt - p0), 64'd4);
        chk("bp_ready_back",  64'(in_ready),     64'd1);
        chk("bp_empty",       64'(out_valid),    64'd0);
        step();

        // Streaming: 20 accepted operands, all results in order
        a0 = acc_cnt; p0 = pop_cnt;
        in_valid = 1'b1;
        n = 0;
        while ((acc_cnt - a0) < 20 && n < 200) begin
            cur_ops = rand_ops();
            step();
            n++;
        end
        in_valid = 1'b0;
        repeat (20) step();
        @(negedge clk);
        chk("stream_accepts", 64'(acc_cnt - a0), 64'd20);
        chk("stream_pops",    64'(pop_cnt - p0), 64'd20);
        step();

        // Reset mid-operation: nothing stale may appear afterwards
        out_ready = 1'b0;
        in_valid  = 1'b1;
        repeat (3) begin cur_ops = rand_ops(); step(); end
        in_valid = 1'b0;
        repeat (2) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        @(negedge clk);
        chk("mid_rst_out_valid", 64'(out_valid), 64'd0);
        chk("mid_rst_in_ready",  64'(in_ready),  64'd1);
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            @(negedge clk);
            chk("mid_rst_no_stale", 64'(out_valid), 64'd0);
        end
        step();
        single("post_rst", '{rr: 64'h2_0000_0000, ii: 64'h1_0000_0000,
                             ri: 64'h0_8000_0000, ir: 64'h0},
               32'h0001_0000, 32'h0000_8000, 1'b0);

        // Random traffic with random backpressure
        for (int i = 0; i < 400; i++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            cur_ops   = rand_ops();
            step();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (20) step();
        @(negedge clk);
        chk("drain_sb_empty",  64'(sb.size()), 64'd0);
        chk("drain_out_valid", 64'(out_valid), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
